// File: rtl/riscv_imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: opcode format classification plus sign-extended
// immediate, registered behind a 2-entry skid buffer. Optional macro: RISCV_IMM_ZICSR_EN.
module riscv_imm_gen_pipe #(
    parameter int IBUS_DATA_WIDTH = 32,
    parameter int DBUS_DATA_WIDTH = 64,
    parameter bit PASS_INSTR      = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IBUS_DATA_WIDTH-1:0] in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DBUS_DATA_WIDTH-1:0] out_imm,
    output logic [5:0]                 out_fmt,
    output logic                       out_illegal,
    output logic [IBUS_DATA_WIDTH-1:0] out_instr
`ifdef RISCV_IMM_ZICSR_EN
    ,
    output logic [11:0]                out_csr_idx
`endif
);

    // state   | meaning
    // S_EMPTY | no entry held, out_valid low
    // S_ONE   | output register holds the oldest entry
    // S_TWO   | output register and skid register both full, in_ready low

    localparam int XLEN = DBUS_DATA_WIDTH;

    if (IBUS_DATA_WIDTH != 32) begin : g_bad_ibus
        $error("riscv_imm_gen_pipe: IBUS_DATA_WIDTH must be 32");
    end
    if (DBUS_DATA_WIDTH != 32 && DBUS_DATA_WIDTH != 64) begin : g_bad_dbus
        $error("riscv_imm_gen_pipe: DBUS_DATA_WIDTH must be 32 or 64");
    end

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    // one-hot bit positions of out_fmt = {J,U,B,S,I,R}
    localparam logic [5:0] FMT_R = 6'b000001;
    localparam logic [5:0] FMT_I = 6'b000010;
    localparam logic [5:0] FMT_S = 6'b000100;
    localparam logic [5:0] FMT_B = 6'b001000;
    localparam logic [5:0] FMT_U = 6'b010000;
    localparam logic [5:0] FMT_J = 6'b100000;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    // ---------------------------------------------------------------
    // Combinational decode of the incoming word
    // ---------------------------------------------------------------
    logic [6:0]                 opc;
    logic [2:0]                 funct3;
    logic signed [31:0]         dec_imm32;
    logic [XLEN-1:0]            dec_imm;
    logic [5:0]                 dec_fmt;
    logic                       dec_illegal;
    logic [IBUS_DATA_WIDTH-1:0] dec_instr;
    logic [11:0]                dec_csr_idx;

    assign opc    = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    always_comb begin
        dec_imm32   = '0;
        dec_fmt     = '0;
        dec_illegal = 1'b0;
        dec_csr_idx = '0;
        unique case (opc)
            OPC_LUI, OPC_AUIPC: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {in_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_MISC_MEM, OPC_SYSTEM: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
`ifdef RISCV_IMM_ZICSR_EN
                // CSRR[WSC]I carry a 5-bit unsigned zimm in the rs1 field
                if (opc == OPC_SYSTEM && (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111)) begin
                    dec_imm32   = {27'b0, in_instr[19:15]};
                    dec_csr_idx = in_instr[31:20];
                end
`endif
            end
            OPC_STORE: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_BRANCH: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OPC_OP, OPC_OP32: begin
                dec_fmt = FMT_R;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

`ifndef RISCV_IMM_ZICSR_EN
    logic unused_funct3;
    assign unused_funct3 = ^funct3;
`endif

    // signed size cast sign-extends to XLEN (identity when XLEN is 32)
    assign dec_imm   = XLEN'(dec_imm32);
    assign dec_instr = PASS_INSTR ? in_instr : '0;

    // ---------------------------------------------------------------
    // Skid buffer
    // ---------------------------------------------------------------
    state_t                     state_q;
    logic                       in_ready_q;
    logic                       out_valid_q;
    logic [XLEN-1:0]            out_imm_q,     skid_imm_q;
    logic [5:0]                 out_fmt_q,     skid_fmt_q;
    logic                       out_illegal_q, skid_illegal_q;
    logic [IBUS_DATA_WIDTH-1:0] out_instr_q,   skid_instr_q;
    logic [11:0]                out_csr_q,     skid_csr_q;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_EMPTY;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_fmt_q      <= '0;
            out_illegal_q  <= 1'b0;
            out_instr_q    <= '0;
            out_csr_q      <= '0;
            skid_imm_q     <= '0;
            skid_fmt_q     <= '0;
            skid_illegal_q <= 1'b0;
            skid_instr_q   <= '0;
            skid_csr_q     <= '0;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        out_imm_q     <= dec_imm;
                        out_fmt_q     <= dec_fmt;
                        out_illegal_q <= dec_illegal;
                        out_instr_q   <= dec_instr;
                        out_csr_q     <= dec_csr_idx;
                        out_valid_q   <= 1'b1;
                        state_q       <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_imm_q     <= dec_imm;
                        out_fmt_q     <= dec_fmt;
                        out_illegal_q <= dec_illegal;
                        out_instr_q   <= dec_instr;
                        out_csr_q     <= dec_csr_idx;
                    end else if (in_xfer) begin
                        skid_imm_q     <= dec_imm;
                        skid_fmt_q     <= dec_fmt;
                        skid_illegal_q <= dec_illegal;
                        skid_instr_q   <= dec_instr;
                        skid_csr_q     <= dec_csr_idx;
                        in_ready_q     <= 1'b0;
                        state_q        <= S_TWO;
                    end else if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_xfer) begin
                        out_imm_q     <= skid_imm_q;
                        out_fmt_q     <= skid_fmt_q;
                        out_illegal_q <= skid_illegal_q;
                        out_instr_q   <= skid_instr_q;
                        out_csr_q     <= skid_csr_q;
                        in_ready_q    <= 1'b1;
                        state_q       <= S_ONE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= S_EMPTY;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_fmt_q;
    assign out_illegal = out_illegal_q;
    assign out_instr   = out_instr_q;

`ifdef RISCV_IMM_ZICSR_EN
    assign out_csr_idx = out_csr_q;
`else
    logic unused_csr;
    assign unused_csr = ^{out_csr_q, skid_csr_q};
`endif

endmodule

// File: tb/tb_riscv_imm_gen_pipe.sv
// Directed, table-driven bench for riscv_imm_gen_pipe at XLEN=64 with PASS_INSTR=1.
// Also covers backpressure ordering, illegal opcodes and reset while two entries are held.
module tb_riscv_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [5:0]  out_fmt;
    logic        out_illegal;
    logic [31:0] out_instr;
`ifdef RISCV_IMM_ZICSR_EN
    logic [11:0] out_csr_idx;
`endif

    riscv_imm_gen_pipe #(
        .IBUS_DATA_WIDTH(32),
        .DBUS_DATA_WIDTH(64),
        .PASS_INSTR(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_illegal(out_illegal),
        .out_instr  (out_instr)
`ifdef RISCV_IMM_ZICSR_EN
        ,
        .out_csr_idx(out_csr_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] F_R = 6'b000001;
    localparam logic [5:0] F_I = 6'b000010;
    localparam logic [5:0] F_S = 6'b000100;
    localparam logic [5:0] F_B = 6'b001000;
    localparam logic [5:0] F_U = 6'b010000;
    localparam logic [5:0] F_J = 6'b100000;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [5:0]  fmt;
        logic        ill;
        logic [11:0] csr;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    function automatic vec_t mk(logic [31:0] i, logic [63:0] m, logic [5:0] f, logic il, logic [11:0] c);
        vec_t v;
        v.instr = i;
        v.imm   = m;
        v.fmt   = f;
        v.ill   = il;
        v.csr   = c;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] addi_k(int k);
        logic [11:0] im;
        im = 12'(k);
        return {im, 20'h00093};
    endfunction

    initial begin
        logic [31:0] rec[$];
        int          sent;
        int          cyc;

        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;

        vecs.push_back(mk(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, F_I, 1'b0, 12'h0));
        vecs.push_back(mk(32'h12345037, 64'h0000_0000_1234_5000, F_U, 1'b0, 12'h0));
        vecs.push_back(mk(32'h800000B7, 64'hFFFF_FFFF_8000_0000, F_U, 1'b0, 12'h0));
        vecs.push_back(mk(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, F_B, 1'b0, 12'h0));
        vecs.push_back(mk(32'hFF9FF06F, 64'hFFFF_FFFF_FFFF_FFF8, F_J, 1'b0, 12'h0));
        vecs.push_back(mk(32'h0020A423, 64'h0000_0000_0000_0008, F_S, 1'b0, 12'h0));
        vecs.push_back(mk(32'h0000007F, 64'h0,                   6'b0, 1'b1, 12'h0));
        vecs.push_back(mk(32'hFFFFFFFF, 64'h0,                   6'b0, 1'b1, 12'h0));
        vecs.push_back(mk(32'h0000006B, 64'h0,                   6'b0, 1'b1, 12'h0));
        vecs.push_back(mk(32'h002081B3, 64'h0,                   F_R, 1'b0, 12'h0));
        vecs.push_back(mk(32'h002081BB, 64'h0,                   F_R, 1'b0, 12'h0));
        vecs.push_back(mk(32'h0080A103, 64'h0000_0000_0000_0008, F_I, 1'b0, 12'h0));
        vecs.push_back(mk(32'h00001097, 64'h0000_0000_0000_1000, F_U, 1'b0, 12'h0));
        vecs.push_back(mk(32'hFFF0809B, 64'hFFFF_FFFF_FFFF_FFFF, F_I, 1'b0, 12'h0));
        vecs.push_back(mk(32'h0FF0000F, 64'h0000_0000_0000_00FF, F_I, 1'b0, 12'h0));
        vecs.push_back(mk(32'h000080E7, 64'h0,                   F_I, 1'b0, 12'h0));
        vecs.push_back(mk(32'h00000073, 64'h0,                   F_I, 1'b0, 12'h0));
        vecs.push_back(mk(32'h00209463, 64'h0000_0000_0000_0008, F_B, 1'b0, 12'h0));
        vecs.push_back(mk(32'h8000006F, 64'hFFFF_FFFF_FFF0_0000, F_J, 1'b0, 12'h0));
`ifdef RISCV_IMM_ZICSR_EN
        vecs.push_back(mk(32'h3401D073, 64'h3,                   F_I, 1'b0, 12'h340));
        vecs.push_back(mk(32'h34011073, 64'h0000_0000_0000_0340, F_I, 1'b0, 12'h0));
`else
        vecs.push_back(mk(32'h3401D073, 64'h0000_0000_0000_0340, F_I, 1'b0, 12'h0));
`endif

        // reset values
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_out_imm", out_imm, 64'h0);
        chk("rst_out_fmt", 64'(out_fmt), 64'h0);
        chk("rst_out_illegal", 64'(out_illegal), 64'h0);
        chk("rst_out_instr", 64'(out_instr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", 64'(in_ready), 64'h0);
        @(negedge clk);
        chk("in_ready_after_release", 64'(in_ready), 64'h1);

        // table: back-to-back stream, consumer always ready
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'h1);
            chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
            chk($sformatf("v%0d_fmt", i), 64'(out_fmt), 64'(vecs[i].fmt));
            chk($sformatf("v%0d_ill", i), 64'(out_illegal), 64'(vecs[i].ill));
            chk($sformatf("v%0d_instr", i), 64'(out_instr), 64'(vecs[i].instr));
`ifdef RISCV_IMM_ZICSR_EN
            chk($sformatf("v%0d_csr", i), 64'(out_csr_idx), 64'(vecs[i].csr));
`endif
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_out_valid", 64'(out_valid), 64'h0);
        chk("drain_in_ready", 64'(in_ready), 64'h1);

        // backpressure: 5 back-to-back words, consumer stalled for the first 3 cycles
        sent = 0;
        rec.delete();
        for (cyc = 0; cyc < 40 && rec.size() < 5; cyc++) begin
            if (cyc == 2) chk("bp_in_ready_full", 64'(in_ready), 64'h0);
            if (cyc >= 1 && cyc <= 3) begin
                chk($sformatf("bp_hold_valid_c%0d", cyc), 64'(out_valid), 64'h1);
                chk($sformatf("bp_hold_imm_c%0d", cyc), out_imm, 64'h1);
            end
            out_ready = (cyc >= 3);
            if (out_valid && out_ready) rec.push_back(out_imm[31:0]);
            if (sent < 5) begin
                in_valid = 1'b1;
                in_instr = addi_k(sent + 1);
                if (in_ready) sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_count", 64'(rec.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < rec.size()) chk($sformatf("bp_order_%0d", k), 64'(rec[k]), 64'(k + 1));
        end
        @(negedge clk);
        chk("bp_no_dup", 64'(out_valid), 64'h0);

        // reset asserted while two entries are held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0000007F;
        @(negedge clk);
        in_instr  = addi_k(9);
        @(negedge clk);
        in_valid  = 1'b0;
        chk("two_in_ready", 64'(in_ready), 64'h0);
        chk("two_head_ill", 64'(out_illegal), 64'h1);
        chk("two_head_imm", out_imm, 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'h0);
        chk("midrst_in_ready", 64'(in_ready), 64'h0);
        chk("midrst_out_instr", 64'(out_instr), 64'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_idle_%0d", c), 64'(out_valid), 64'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/riscv_imm_gen_pipe.md
Name: riscv_imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage.
- Accepts a fetched instruction over a valid/ready handshake.
- Classifies the opcode into R/I/S/B/U/J format (one-hot) and produces the sign-extended immediate at XLEN width.
- Registers both outputs behind a 2-entry skid buffer, so downstream backpressure never drops or reorders instructions.
- Sits between the fetch-side instruction queue and the register-read/ALU-operand mux.

Parameters:
IBUS_DATA_WIDTH, 32, instruction width; only 32 is supported (elaboration error otherwise).
DBUS_DATA_WIDTH, 64, XLEN of the immediate output; 32 or 64.
PASS_INSTR, 1, 1 = carry the raw instruction alongside the immediate; 0 = out_instr is driven to 0.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
in_valid  input  1  instruction word valid.
in_ready  output  1  block can accept an instruction this cycle.
in_instr  input  IBUS_DATA_WIDTH  instruction word.
out_valid  output  1  immediate/format valid.
out_ready  input  1  consumer accepts the output this cycle.
out_imm  output  DBUS_DATA_WIDTH  sign-extended immediate.
out_fmt  output  6  one-hot format {J,U,B,S,I,R}.
out_illegal  output  1  opcode not recognised.
out_instr  output  IBUS_DATA_WIDTH  raw instruction (PASS_INSTR=1).

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, in_ready=0, skid buffer empty.
  - out_imm, out_fmt, out_illegal and out_instr are all 0.
  - in_ready rises in the first cycle after rst_n deasserts.
- Opcode decode on in_instr[6:0]:
  - U: 0110111 (LUI), 0010111 (AUIPC).
  - J: 1101111 (JAL).
  - I: 1100111 (JALR), 0000011 (LOAD), 0010011 (OP-IMM), 0011011 (OP-IMM-32), 0001111 (MISC-MEM), 1110011 (SYSTEM).
  - S: 0100011 (STORE).
  - B: 1100011 (BRANCH).
  - R: 0110011 (OP), 0111011 (OP-32).
  - Anything else: out_fmt=0, out_illegal=1, out_imm=0.
- Immediate assembly, each field sign-extended from its top bit to DBUS_DATA_WIDTH:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}; for XLEN=64, bits 63:32 are copies of instr[31].
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R and illegal: 0.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Latency is 1 cycle: an instruction accepted at edge N is presented on the outputs after edge N.
- Skid buffer, states EMPTY, ONE, TWO (counts held entries):
  - EMPTY: in_ready=1, out_valid=0. An input transfer goes to ONE.
  - ONE: in_ready=1, out_valid=1.
    - Input and output together: stay in ONE; the output register is refilled with the new instruction.
    - Input only: go to TWO; the new instruction is held in the skid register.
    - Output only: go to EMPTY.
  - TWO: in_ready=0, out_valid=1.
    - An output transfer moves the skid register into the output register and goes to ONE.
    - in_valid is ignored.
- Outputs are registered only; no combinational path from in_* to out_*, nor from out_ready to in_ready.
- Order is strictly FIFO. in_instr is sampled only on a transfer; changes while in_ready=0 are ignored.
- Output stability: while out_valid=1 and out_ready=0, all out_* signals hold stable.
- Reset mid-operation: contents are flushed, no partial output; out_valid drops asynchronously.

Optional Feature:
RISCV_IMM_ZICSR_EN:
- Defined: for SYSTEM with funct3 in {101, 110, 111} (CSRRWI/CSRRSI/CSRRCI):
  - out_imm = zero-extended instr[19:15] (zimm).
  - out_fmt = I.
  - Extra output out_csr_idx (12 bits) = instr[31:20], registered with the same timing.
- Undefined: those instructions use the plain I-type immediate; the out_csr_idx port does not exist.

Test Plan:
- XLEN=64, in_instr=0xFFF00093 (ADDI x1,x0,-1), out_ready=1 → next cycle out_imm=0xFFFF_FFFF_FFFF_FFFF, out_fmt=I, out_illegal=0.
- LUI 0x12345037 → out_imm=0x0000_0000_1234_5000, fmt=U. Then 0x800000B7 → 0xFFFF_FFFF_8000_0000.
- Branch/jump/store immediates:
  - BEQ 0xFE000EE3 → imm=-4.
  - JAL 0xFF9FF06F → imm=-8.
  - SW 0x0020A423 → imm=8, fmt=S.
- Backpressure: stream 5 back-to-back instructions with out_ready=0 for 3 cycles →
  - in_ready=0 once 2 entries are held.
  - After out_ready=1, all 5 emerge in order; no duplicates and no loss.
- in_instr=0x0000007F → out_illegal=1, out_fmt=0, out_imm=0. rst_n pulsed low while in TWO → out_valid=0 immediately, nothing emitted after release.
- With RISCV_IMM_ZICSR_EN, CSRRWI 0x3401D073 → out_imm=3, out_csr_idx=0x340.
